uvmt_cv32e40x_exceptions_sched: RTL and testbench
=================================================

// Module: uvmt_cv32e40x_exceptions_sched
// PURPOSE
//  Bench-side exception scheduler/checker for the CV32E40X exceptions interface.
//  - Each cycle with WB valid: arbitrates the per-instruction exception flags down to one
//    expected mcause, using RISC-V synchronous-exception priority.
//  - Queues expected causes in a small FIFO and sequences them against observed trap entries.
//  - Flags mismatch, timeout, overflow and unexpected traps.
//  - Instantiated beside the exceptions assertion module; driven from uvmt_cv32e40x_exceptions_if.
// PARAMETERS
//  DEPTH    4   expected-exception FIFO entries (power of 2, >=2)
//  MAX_LAT  16  max cycles from an entry reaching FIFO head to its trap entry (1..255)
// PORTS
//  clk_i            in   1  clock
//  rst_i            in   1  asynchronous reset, active-high
//  wb_valid_i       in   1  instruction retires/excepts in WB this cycle
//  exc_flags_i      in   6  [5]instr brkpt [4]ibus pma [3]ibus buserr [2]illegal [1]ecall [0]ebreak
//  trap_valid_i     in   1  core enters trap handler this cycle
//  trap_cause_i     in   6  mcause[5:0] written at trap entry
//  exp_valid_o      out  1  FIFO head holds an expected exception
//  exp_cause_o      out  6  mcause of FIFO head
//  pend_cnt_o       out  $clog2(DEPTH)+1  number of queued expectations
//  err_mismatch_o   out  1  pulse: trap cause != head cause
//  err_timeout_o    out  1  pulse: head waited MAX_LAT cycles without a trap
//  err_overflow_o   out  1  pulse: push attempted with FIFO full
//  err_unexp_o      out  1  pulse: trap observed with FIFO empty
// BEHAVIOUR
//  - Reset: FIFO empty; state IDLE; wait counter 0; every output 0.
//  - Arbiter, combinational. Highest set flag wins: [5]->3, [4]->1, [3]->24, [2]->2, [1]->11, [0]->3.
//  - Push: wb_valid_i && |exc_flags_i. Entry is visible at the head the next cycle (latency 1).
//    Push is ignored when exc_flags_i==0.
//  - FSM IDLE: FIFO empty. Go to WAIT on the cycle after a push.
//  - FSM WAIT: head valid; 8-bit wait counter increments each cycle.
//    - Counter clears whenever the head pops or a new head is presented.
//    - trap_valid_i, cause==head: pop; no error.
//    - trap_valid_i, cause!=head: pop; err_mismatch_o pulses 1 cycle.
//    - No trap and counter==MAX_LAT-1: pop; err_timeout_o pulses.
//    - After a pop: stay in WAIT if entries remain, else go to IDLE.
//  - Trap in IDLE (FIFO empty, no same-cycle pop): err_unexp_o pulses; no state change.
//  - Simultaneous push+pop: both take effect; count unchanged; allowed when full, since pop frees a slot.
//  - Push when full with no pop: entry dropped; err_overflow_o pulses; FIFO contents untouched.
//  - Pointers wrap modulo DEPTH; pend_cnt_o ranges 0..DEPTH.
//  - Error pulses are registered: asserted the cycle after the causing event.
//  - Reset asserted mid-operation clears the FIFO, the counter and all pulses immediately.
// CONFIGURATION
//  UVMT_CV32E40X_EXC_SCHED_COV_EN
//  - Defined:
//    - adds six 16-bit saturating per-cause counters, incremented on each matched pop;
//    - adds output cov_cnt_o[95:0], six 16-bit fields ordered as exc_flags_i bits;
//    - adds a cover property per cause.
//  - Undefined: counters, port and covers absent; all other behaviour identical.
// TESTING
//  T1 illegal (flags=6'b000100) at WB; trap cause 2 three cycles later -> exp_cause_o=2; no error pulses; FIFO empty after.
//  T2 flags=6'b101001, trap cause 3 -> instr breakpoint wins, exp_cause_o=3, match; repeat with trap cause 11 -> err_mismatch_o=1 for 1 cycle.
//  T3 ecall pushed, no trap -> err_timeout_o pulses exactly MAX_LAT=16 cycles after head valid; pend_cnt_o returns 0.
//  T4 five pushes back-to-back with DEPTH=4, no traps -> err_overflow_o on 5th; pend_cnt_o=4; head cause = 1st push.
//  T5 trap_valid_i=1 with FIFO empty -> err_unexp_o=1; same-cycle push+trap when full -> no overflow; count stays 4.
//  T6 rst_i asserted with 3 entries pending -> next cycle all outputs 0, IDLE; subsequent push behaves as T1.

Source files
------------

// File: rtl/uvmt_cv32e40x_exceptions_sched.sv
// Expected-exception scheduler: arbitrates WB exception flags to an mcause, queues it,
// and checks it against observed trap entries. Optional coverage: UVMT_CV32E40X_EXC_SCHED_COV_EN.
module uvmt_cv32e40x_exceptions_sched #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned MAX_LAT = 16
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       wb_valid_i,
   input  logic [5:0]                 exc_flags_i,
   input  logic                       trap_valid_i,
   input  logic [5:0]                 trap_cause_i,
   output logic                       exp_valid_o,
   output logic [5:0]                 exp_cause_o,
   output logic [$clog2(DEPTH):0]     pend_cnt_o,
   output logic                       err_mismatch_o,
   output logic                       err_timeout_o,
   output logic                       err_overflow_o,
`ifdef UVMT_CV32E40X_EXC_SCHED_COV_EN
   output logic [95:0]                cov_cnt_o,
`endif
   output logic                       err_unexp_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = 8;

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   state_t          state;
   logic [5:0]      fifo_cause [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_nxt;
   logic [TW-1:0]   wait_cnt;

   logic [5:0]      arb_cause;
   logic [5:0]      head_cause;
   logic            push;
   logic            full;
   logic            pop;
   logic            do_push;
   logic            lat_expired;
   logic            mismatch;
   logic            timeout;
   logic            overflow;
   logic            unexp;

`ifdef UVMT_CV32E40X_EXC_SCHED_COV_EN
   logic [2:0]      arb_idx;
   logic [2:0]      fifo_idx [DEPTH];
   logic [2:0]      head_idx;
   logic [15:0]     cov_cnt [6];
   logic            match_pop;
`endif

   // Synchronous-exception priority: breakpoint > ibus pma > ibus error > illegal > ecall > ebreak
   always_comb begin
      arb_cause = 6'd0;
`ifdef UVMT_CV32E40X_EXC_SCHED_COV_EN
      arb_idx   = 3'd0;
`endif
      if (exc_flags_i[5]) begin
         arb_cause = 6'd3;
`ifdef UVMT_CV32E40X_EXC_SCHED_COV_EN
         arb_idx   = 3'd5;
`endif
      end else if (exc_flags_i[4]) begin
         arb_cause = 6'd1;
`ifdef UVMT_CV32E40X_EXC_SCHED_COV_EN
         arb_idx   = 3'd4;
`endif
      end else if (exc_flags_i[3]) begin
         arb_cause = 6'd24;
`ifdef UVMT_CV32E40X_EXC_SCHED_COV_EN
         arb_idx   = 3'd3;
`endif
      end else if (exc_flags_i[2]) begin
         arb_cause = 6'd2;
`ifdef UVMT_CV32E40X_EXC_SCHED_COV_EN
         arb_idx   = 3'd2;
`endif
      end else if (exc_flags_i[1]) begin
         arb_cause = 6'd11;
`ifdef UVMT_CV32E40X_EXC_SCHED_COV_EN
         arb_idx   = 3'd1;
`endif
      end else if (exc_flags_i[0]) begin
         arb_cause = 6'd3;
`ifdef UVMT_CV32E40X_EXC_SCHED_COV_EN
         arb_idx   = 3'd0;
`endif
      end
   end

   assign head_cause  = fifo_cause[rd_ptr];
   assign push        = wb_valid_i && (exc_flags_i != 6'd0);
   assign full        = (count == CW'(DEPTH));
   assign lat_expired = (wait_cnt == TW'(MAX_LAT - 1));
   assign pop         = (state == ST_WAIT) && (trap_valid_i || lat_expired);
   // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then
   assign do_push     = push && (!full || pop);
   assign mismatch    = (state == ST_WAIT) && trap_valid_i && (trap_cause_i != head_cause);
   assign timeout     = (state == ST_WAIT) && !trap_valid_i && lat_expired;
   assign overflow    = push && full && !pop;
   assign unexp       = (state == ST_IDLE) && trap_valid_i;

   always_comb begin
      count_nxt = count;
      if (do_push && !pop) begin
         count_nxt = count + CW'(1);
      end else if (!do_push && pop) begin
         count_nxt = count - CW'(1);
      end
   end

   // FIFO, FSM, wait counter and registered error pulses
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state          <= ST_IDLE;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count          <= '0;
         wait_cnt       <= '0;
         err_mismatch_o <= 1'b0;
         err_timeout_o  <= 1'b0;
         err_overflow_o <= 1'b0;
         err_unexp_o    <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            fifo_cause[i] <= 6'd0;
`ifdef UVMT_CV32E40X_EXC_SCHED_COV_EN
            fifo_idx[i]   <= 3'd0;
`endif
         end
      end else begin
         if (do_push) begin
            fifo_cause[wr_ptr] <= arb_cause;
`ifdef UVMT_CV32E40X_EXC_SCHED_COV_EN
            fifo_idx[wr_ptr]   <= arb_idx;
`endif
            wr_ptr             <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count_nxt;

         unique case (state)
            ST_IDLE: begin
               wait_cnt <= '0;
               if (do_push) begin
                  state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (pop) begin
                  wait_cnt <= '0;
                  if (count_nxt == '0) begin
                     state <= ST_IDLE;
                  end
               end else begin
                  wait_cnt <= wait_cnt + TW'(1);
               end
            end
            default: begin
               state    <= ST_IDLE;
               wait_cnt <= '0;
            end
         endcase

         err_mismatch_o <= mismatch;
         err_timeout_o  <= timeout;
         err_overflow_o <= overflow;
         err_unexp_o    <= unexp;
      end
   end

   assign exp_valid_o = (state == ST_WAIT);
   assign exp_cause_o = (state == ST_WAIT) ? head_cause : 6'd0;
   assign pend_cnt_o  = count;

`ifdef UVMT_CV32E40X_EXC_SCHED_COV_EN
   assign head_idx  = fifo_idx[rd_ptr];
   assign match_pop = (state == ST_WAIT) && trap_valid_i && (trap_cause_i == head_cause);

   // Saturating per-cause match counters, indexed like exc_flags_i
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int k = 0; k < 6; k++) begin
            cov_cnt[k] <= 16'd0;
         end
      end else begin
         for (int k = 0; k < 6; k++) begin
            if (match_pop && (head_idx == 3'(k)) && (cov_cnt[k] != 16'hFFFF)) begin
               cov_cnt[k] <= cov_cnt[k] + 16'd1;
            end
         end
      end
   end

   for (genvar g = 0; g < 6; g++) begin : g_cov
      assign cov_cnt_o[g*16 +: 16] = cov_cnt[g];
      c_cause: cover property (@(posedge clk_i) disable iff (rst_i) match_pop && (head_idx == 3'(g)));
   end
`endif

endmodule

// File: tb/tb_uvmt_cv32e40x_exceptions_sched.sv
// Directed self-checking bench for uvmt_cv32e40x_exceptions_sched (DEPTH=4, MAX_LAT=16).
module tb_uvmt_cv32e40x_exceptions_sched;

   logic       clk;
   logic       rst;
   logic       wb_valid;
   logic [5:0] exc_flags;
   logic       trap_valid;
   logic [5:0] trap_cause;
   logic       exp_valid;
   logic [5:0] exp_cause;
   logic [2:0] pend_cnt;
   logic       err_mismatch;
   logic       err_timeout;
   logic       err_overflow;
   logic       err_unexp;

   int vectors     = 0;
   int miscompares = 0;

   uvmt_cv32e40x_exceptions_sched #(.DEPTH(4), .MAX_LAT(16)) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .wb_valid_i     (wb_valid),
      .exc_flags_i    (exc_flags),
      .trap_valid_i   (trap_valid),
      .trap_cause_i   (trap_cause),
      .exp_valid_o    (exp_valid),
      .exp_cause_o    (exp_cause),
      .pend_cnt_o     (pend_cnt),
      .err_mismatch_o (err_mismatch),
      .err_timeout_o  (err_timeout),
      .err_overflow_o (err_overflow),
      .err_unexp_o    (err_unexp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // errs packs {mismatch, timeout, overflow, unexp}
   task automatic chk_all(input string tag, input logic v, input logic [5:0] c,
                          input logic [2:0] p, input logic [3:0] errs);
      chk({tag, "_valid"}, 32'(exp_valid), 32'(v));
      chk({tag, "_cause"}, 32'(exp_cause), 32'(c));
      chk({tag, "_pend"},  32'(pend_cnt),  32'(p));
      chk({tag, "_errs"},  32'({err_mismatch, err_timeout, err_overflow, err_unexp}), 32'(errs));
   endtask

   initial begin
      rst        = 1'b1;
      wb_valid   = 1'b0;
      exc_flags  = 6'd0;
      trap_valid = 1'b0;
      trap_cause = 6'd0;
      tick();
      tick();
      chk_all("reset", 1'b0, 6'd0, 3'd0, 4'b0000);
      rst = 1'b0;
      tick();
      chk_all("idle", 1'b0, 6'd0, 3'd0, 4'b0000);

      // T1: illegal instruction, matching trap three cycles later
      wb_valid = 1'b1; exc_flags = 6'b000100;
      tick();
      chk_all("t1_push", 1'b1, 6'd2, 3'd1, 4'b0000);
      wb_valid = 1'b0; exc_flags = 6'd0;
      tick();
      tick();
      chk_all("t1_hold", 1'b1, 6'd2, 3'd1, 4'b0000);
      trap_valid = 1'b1; trap_cause = 6'd2;
      tick();
      chk_all("t1_trap", 1'b0, 6'd0, 3'd0, 4'b0000);
      trap_valid = 1'b0;
      tick();
      chk_all("t1_after", 1'b0, 6'd0, 3'd0, 4'b0000);

      // T2: breakpoint beats ibus error and ebreak; match, then mismatch
      wb_valid = 1'b1; exc_flags = 6'b101001;
      tick();
      chk_all("t2_push_a", 1'b1, 6'd3, 3'd1, 4'b0000);
      wb_valid = 1'b0; exc_flags = 6'd0;
      trap_valid = 1'b1; trap_cause = 6'd3;
      tick();
      chk_all("t2_match", 1'b0, 6'd0, 3'd0, 4'b0000);
      trap_valid = 1'b0;
      wb_valid = 1'b1; exc_flags = 6'b101001;
      tick();
      chk_all("t2_push_b", 1'b1, 6'd3, 3'd1, 4'b0000);
      wb_valid = 1'b0; exc_flags = 6'd0;
      trap_valid = 1'b1; trap_cause = 6'd11;
      tick();
      chk_all("t2_mismatch", 1'b0, 6'd0, 3'd0, 4'b1000);
      trap_valid = 1'b0;
      tick();
      chk_all("t2_pulse_end", 1'b0, 6'd0, 3'd0, 4'b0000);

      // T2b: ibus pma beats ibus error, illegal, ecall
      wb_valid = 1'b1; exc_flags = 6'b011110;
      tick();
      chk("t2_pma_cause", 32'(exp_cause), 32'd1);
      wb_valid = 1'b0; exc_flags = 6'd0;
      trap_valid = 1'b1; trap_cause = 6'd1;
      tick();
      chk_all("t2_pma_pop", 1'b0, 6'd0, 3'd0, 4'b0000);
      trap_valid = 1'b0;

      // T3: ecall with no trap times out 16 cycles after the head became valid
      wb_valid = 1'b1; exc_flags = 6'b000010;
      tick();
      chk_all("t3_push", 1'b1, 6'd11, 3'd1, 4'b0000);
      wb_valid = 1'b0; exc_flags = 6'd0;
      for (int i = 1; i < 16; i++) tick();
      chk_all("t3_pre_timeout", 1'b1, 6'd11, 3'd1, 4'b0000);
      tick();
      chk_all("t3_timeout", 1'b0, 6'd0, 3'd0, 4'b0100);
      tick();
      chk_all("t3_pulse_end", 1'b0, 6'd0, 3'd0, 4'b0000);

      // T5a: trap with empty FIFO
      trap_valid = 1'b1; trap_cause = 6'd5;
      tick();
      chk_all("t5_unexp", 1'b0, 6'd0, 3'd0, 4'b0001);
      trap_valid = 1'b0;
      tick();
      chk_all("t5_unexp_end", 1'b0, 6'd0, 3'd0, 4'b0000);

      // T4: five back-to-back pushes into a 4-deep FIFO
      wb_valid = 1'b1;
      exc_flags = 6'b000100; tick();
      chk_all("t4_p1", 1'b1, 6'd2, 3'd1, 4'b0000);
      exc_flags = 6'b000010; tick();
      exc_flags = 6'b001000; tick();
      exc_flags = 6'b010000; tick();
      chk_all("t4_p4", 1'b1, 6'd2, 3'd4, 4'b0000);
      exc_flags = 6'b000001; tick();
      chk_all("t4_overflow", 1'b1, 6'd2, 3'd4, 4'b0010);
      wb_valid = 1'b0; exc_flags = 6'd0;
      tick();
      chk_all("t4_pulse_end", 1'b1, 6'd2, 3'd4, 4'b0000);

      // T5b: push and matching trap together while full
      wb_valid = 1'b1; exc_flags = 6'b000001;
      trap_valid = 1'b1; trap_cause = 6'd2;
      tick();
      chk_all("t5_push_pop_full", 1'b1, 6'd11, 3'd4, 4'b0000);
      wb_valid = 1'b0; exc_flags = 6'd0;
      trap_cause = 6'd11;
      tick();
      chk_all("t5_pop_to3", 1'b1, 6'd24, 3'd3, 4'b0000);
      trap_valid = 1'b0;

      // T6: asynchronous reset with 3 pending, then normal operation
      rst = 1'b1;
      #1;
      chk_all("t6_async_rst", 1'b0, 6'd0, 3'd0, 4'b0000);
      tick();
      chk_all("t6_rst_held", 1'b0, 6'd0, 3'd0, 4'b0000);
      rst = 1'b0;
      tick();
      chk_all("t6_idle", 1'b0, 6'd0, 3'd0, 4'b0000);
      wb_valid = 1'b1; exc_flags = 6'b000100;
      tick();
      chk_all("t6_push", 1'b1, 6'd2, 3'd1, 4'b0000);
      wb_valid = 1'b0; exc_flags = 6'd0;
      tick();
      trap_valid = 1'b1; trap_cause = 6'd2;
      tick();
      chk_all("t6_trap", 1'b0, 6'd0, 3'd0, 4'b0000);
      trap_valid = 1'b0;
      tick();
      chk_all("t6_after", 1'b0, 6'd0, 3'd0, 4'b0000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
